// File: rtl/qdiv_pkg.sv
// Shared types and helpers for the sequential sign-magnitude Q-format divider.
package qdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Helpers work on a fixed wide word; callers narrow the result with a size cast.
  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] sm_max(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] sm_abs(input logic [MAX_W-1:0] word,
                                              input int unsigned     n);
    return word & sm_max(n);
  endfunction

endpackage

// File: rtl/qdiv_restore_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module qdiv_restore_step #(
  parameter int unsigned N = 32
) (
  input  logic [N-2:0] rem_i,
  input  logic [N-2:0] div_i,
  input  logic         bit_i,
  output logic [N-2:0] rem_o,
  output logic         q_o
);

  logic [N-1:0] trial;

  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = trial >= {1'b0, div_i};
    // Remainder stays below the divisor, so N-1 bits always suffice after the step.
    rem_o = q_o ? (N-1)'(trial - {1'b0, div_i}) : trial[N-2:0];
  end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider, one quotient bit per clock,
// with valid/ready handshakes, divide-by-zero and overflow saturation.
module qdiv_seq
  import qdiv_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int unsigned ITER = N - 1 + Q;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam logic [N-2:0] MAG_MAX = (N-1)'(sm_max(N));

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-2:0]    rem_q, rem_d;
  logic [N-2:0]    bmag_q, bmag_d;
  logic [ITER-1:0] dvd_q, dvd_d;
  logic [ITER-1:0] quo_q, quo_d;
  logic            sign_q, sign_d;
  logic            dbz_q, dbz_d;
  logic            init_q, init_d;

  logic [N-2:0] a_mag, b_mag;
  logic [N-2:0] step_rem;
  logic         step_q;
  logic         ovf_raw;
  logic [N-2:0] mag;

  qdiv_restore_step #(.N(N)) u_step (
    .rem_i (rem_q),
    .div_i (bmag_q),
    .bit_i (dvd_q[ITER-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    a_mag = (N-1)'(sm_abs(64'(dividend), N));
    b_mag = (N-1)'(sm_abs(64'(divisor), N));

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    bmag_d   = bmag_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    sign_d   = sign_q;
    dbz_d    = dbz_q;
    init_d   = 1'b1;
    in_ready = 1'b0;

    unique case (state_q)
      IDLE: in_ready = init_q;
      CALC: begin
        rem_d = step_rem;
        dvd_d = dvd_q << 1;
        quo_d = {quo_q[ITER-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept overrides the state's own transition; this gives back-to-back issue from DONE.
    if (in_valid && in_ready) begin
      sign_d = dividend[N-1] ^ divisor[N-1];
      bmag_d = b_mag;
      dvd_d  = ITER'(a_mag) << Q;
      rem_d  = '0;
      cnt_d  = '0;
      dbz_d  = (b_mag == '0);
      quo_d  = '0;
      if (b_mag == '0) begin
        quo_d   = ITER'(MAG_MAX);
        state_d = DONE;
        if (a_mag == '0) sign_d = 1'b0;
      end else begin
        state_d = CALC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      sign_q  <= 1'b0;
      dbz_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      sign_q  <= sign_d;
      dbz_q   <= dbz_d;
      init_q  <= init_d;
    end
  end

  // Any set bit above the N-1 magnitude bits means the true quotient does not fit.
  always_comb begin
    out_valid   = (state_q == DONE);
    ovf_raw     = (quo_q >> (N - 1)) != '0;
    mag         = ovf_raw ? MAG_MAX : quo_q[N-2:0];
    quotient    = out_valid ? {sign_q & (mag != '0), mag} : '0;
    div_by_zero = out_valid & dbz_q;
    overflow    = out_valid & ovf_raw & ~dbz_q;
  end

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed vector table, handshake/reset sequences,
// and randomized operands against an arithmetic reference model.
module tb_qdiv_seq;

  localparam int unsigned N = 32;
  localparam int unsigned Q = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic         div_by_zero;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  qdiv_seq #(.N(N), .Q(Q)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vec[13];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer division of magnitudes, then saturate and sign rules.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned am, bm, m, maxm;
    logic s, dz, ov;
    logic [31:0] r;
    maxm = (64'd1 << (N - 1)) - 1;
    am = a & maxm;
    bm = b & maxm;
    s  = a[N-1] ^ b[N-1];
    dz = 1'b0;
    ov = 1'b0;
    if (bm == 0) begin
      dz = 1'b1;
      m  = maxm;
      if (am == 0) s = 1'b0;
    end else begin
      m = (am << Q) / bm;
      if (m > maxm) begin
        ov = 1'b1;
        m  = maxm;
      end
      if (m == 0) s = 1'b0;
    end
    r = {s, 31'(m)};
    return {dz, ov, r};
  endfunction

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    int t = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("consume_valid_low", out_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [33:0] m;

    vec[0]  = '{32'h00018000, 32'h00010000, 32'h0000C000, 1'b0, 1'b0, 47};
    vec[1]  = '{32'h80018000, 32'h00010000, 32'h8000C000, 1'b0, 1'b0, 47};
    vec[2]  = '{32'h80000000, 32'h00010000, 32'h00000000, 1'b0, 1'b0, 47};
    vec[3]  = '{32'h00008000, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1};
    vec[4]  = '{32'h40000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 47};
    vec[5]  = '{32'h00000001, 32'h00010000, 32'h00000000, 1'b0, 1'b0, 47};
    vec[6]  = '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
    vec[7]  = '{32'h80008000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1};
    vec[8]  = '{32'h00008000, 32'h00008000, 32'h00008000, 1'b0, 1'b0, 47};
    vec[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00008000, 1'b0, 1'b0, 47};
    vec[10] = '{32'h80000001, 32'h00010000, 32'h00000000, 1'b0, 1'b0, 47};
    vec[11] = '{32'h0000FFFF, 32'h00000001, 32'h7FFF8000, 1'b0, 1'b0, 47};
    vec[12] = '{32'h00010000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 47};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("rel_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1 chk("rel_in_ready_high", in_ready, 1);
    @(negedge clk);

    foreach (vec[i]) begin
      start_op(vec[i].a, vec[i].b);
      wait_result(lat);
      chk($sformatf("v%0d_lat", i), lat, vec[i].lat);
      chk($sformatf("v%0d_q", i), quotient, vec[i].q);
      chk($sformatf("v%0d_dbz", i), div_by_zero, vec[i].dbz);
      chk($sformatf("v%0d_ovf", i), overflow, vec[i].ovf);
      consume();
    end

    // Stall the consumer, then hand over and issue in the same cycle.
    start_op(32'h00018000, 32'h00010000);
    wait_result(lat);
    chk("stall_lat", lat, 47);
    for (int k = 0; k < 10; k++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_q", quotient, 32'h0000C000);
      chk("stall_flags", {div_by_zero, overflow}, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dividend  = 32'h00008000;
    divisor   = 32'h00008000;
    #1 chk("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_valid_drop", out_valid, 0);
    wait_result(lat);
    chk("b2b_lat", lat, 47);
    chk("b2b_q", quotient, 32'h00008000);
    consume();

    // Reset during CALC aborts the operation.
    start_op(32'h00018000, 32'h00010000);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_q", quotient, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("abort_rel_in_ready", in_ready, 0);
    @(posedge clk);
    #1 chk("abort_rel_in_ready_high", in_ready, 1);
    repeat (50) @(negedge clk);
    chk("abort_no_result", out_valid, 0);
    start_op(32'h00008000, 32'h00008000);
    wait_result(lat);
    chk("post_rst_lat", lat, 47);
    chk("post_rst_q", quotient, 32'h00008000);
    consume();

    // Reset while a flagged result is held clears outputs without a clock edge.
    start_op(32'h00008000, 32'h80000000);
    wait_result(lat);
    chk("held_dbz", div_by_zero, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_q", quotient, 0);
    chk("async_dbz", div_by_zero, 0);
    chk("async_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, b;
      int mode, d;
      a    = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0)      b = {1'($urandom), 31'd0};
      else if (mode < 3)  b = {1'($urandom), 31'($urandom_range(1, 255))};
      else if (mode < 5)  b = {1'($urandom), 31'($urandom)};
      else                b = {1'($urandom), 31'($urandom_range(1, 32'h00FFFFFF))};
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'($urandom_range(0, 32'h0003FFFF))};
      m = model(a, b);
      start_op(a, b);
      wait_result(lat);
      chk("rnd_lat", lat, m[33] ? 1 : 47);
      chk("rnd_q", quotient, m[31:0]);
      chk("rnd_dbz", div_by_zero, m[33]);
      chk("rnd_ovf", overflow, m[32]);
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(negedge clk);
        chk("rnd_hold_q", quotient, m[31:0]);
      end
      consume();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
